mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Data-memory access unit between the decode/execute stage and a word-wide synchronous data RAM. Consumes the decoder's memory control (`datamem_read_enable`, `datamem_write_enable`, `word_size`, `word_size2`, `load_signed`), the ALU-computed address and the store data. It performs the access: sign/zero-extended byte/halfword/word loads and word stores, plus byte/halfword stores via read-modify-write. It stalls the pipeline while a multi-cycle access is in flight.

## Interface
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, data width; fixed at 32, other values unsupported
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `datamem_read_enable`  in  1  load request this cycle
- `datamem_write_enable`  in  1  store request this cycle
- `word_size`  in  2  store size: 00 byte, 01 half, 11 word (10 treated as word)
- `word_size2`  in  2  load size, same encoding
- `load_signed`  in  1  1 = sign-extend sub-word load, 0 = zero-extend
- `addr`  in  ADDR_W  byte address
- `store_data`  in  32  store operand (sub-word stores use low bits)
- `stall`  out  1  request must be held unchanged while high
- `load_data`  out  32  extended load result
- `load_valid`  out  1  `load_data` valid this cycle
- `access_err`  out  1  one-cycle pulse: misaligned access or both enables high
- `mem_addr`  out  ADDR_W-2  RAM word address (`addr[ADDR_W-1:2]`)
- `mem_rd`  out  1  RAM read strobe; data returns on `mem_rdata` next cycle
- `mem_wr`  out  1  RAM write strobe, written at this edge
- `mem_wdata`  out  32  RAM write data
- `mem_rdata`  in  32  RAM read data, valid cycle after `mem_rd`

## Operation
- Byte order is big-endian. Byte offset 0 maps to bits [31:24], offset 3 maps to [7:0]. Halfword `addr[1]`=0 maps to [31:16].
- FSM states: IDLE, RD_WAIT, RMW_WAIT, RMW_WRITE. Reset state is IDLE.
- IDLE:
  - no enable → outputs inactive.
  - both enables high → `access_err`=1, no RAM access, stay IDLE.
  - misaligned → `access_err`=1, no RAM access, `stall`=0, stay IDLE. Misaligned means half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - aligned load → `mem_rd`=1, `stall`=1, go to RD_WAIT.
  - aligned word store → `mem_wr`=1, `mem_wdata`=`store_data`, `stall`=0, stay IDLE.
  - aligned byte/half store → `mem_rd`=1, `stall`=1, go to RMW_WAIT.
- RD_WAIT: `load_valid`=1, `stall`=0. `load_data` is the selected lane of `mem_rdata`, extended per `load_signed`; a word load passes through. Go to IDLE.
- RMW_WAIT: register the merged word. The merge is `mem_rdata` with the addressed lane replaced by `store_data[7:0]` (byte) or `store_data[15:0]` (half). `stall`=1, go to RMW_WRITE.
- RMW_WRITE: `mem_wr`=1, `mem_wdata`=merged register, `stall`=0, go to IDLE.
- `mem_addr` is driven from `addr` in every state (request held stable under stall).
- Outputs are combinational from state + inputs, except the merge register.

## Timing
- Reset values (while `rst` high and the cycle after): state IDLE, merge register 0. `stall`, `load_valid`, `access_err`, `mem_rd` and `mem_wr` are 0; `load_data` and `mem_wdata` are 0.
- Load: 2 cycles, `stall` high 1 cycle, `load_valid` in 2nd cycle.
- Word store: 1 cycle, no stall.
- Sub-word store: 3 cycles, `stall` high 2 cycles, RAM write in 3rd cycle.
- A new request is accepted in the cycle following RD_WAIT/RMW_WRITE (back-to-back, no bubble).
- `rst` asserted in any state → IDLE on that edge. A pending RMW write is dropped and `mem_wr` is never asserted from RMW_WRITE.
- Enables changing while `stall`=1 is a protocol violation; the FSM ignores the inputs until it returns to IDLE.

## Test plan
- RAM[0x10]=0x8034_56F0. LB `addr`=0x10 → `load_valid` cycle 2, `load_data`=0xFFFF_FF80. LBU → 0x0000_0080. LH `addr`=0x12 → 0x0000_56F0. LW → 0x8034_56F0.
- SB `addr`=0x13, `store_data`=0x0000_00AB on RAM 0x1122_3344 → `stall` high 2 cycles, then `mem_wr` with 0x1122_33AB. SH `addr`=0x10, `store_data`=0xBEEF → 0xBEEF_3344.
- SW `addr`=0x20, `store_data`=0xDEAD_BEEF → `mem_wr` same cycle, `stall`=0, `mem_addr`=0x8.
- LW `addr`=0x21, then SH `addr`=0x23, then both enables high → `access_err` pulse each cycle, `mem_rd`=`mem_wr`=0, `stall`=0.
- SB issued, `rst` pulsed in RMW_WAIT → no `mem_wr`, next cycle IDLE, all outputs 0.
- LW then SW back-to-back → `load_valid` cycle 2, `mem_wr` cycle 3, no idle cycle between.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: big-endian data-memory access with sub-word loads and read-modify-write sub-word stores
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              datamem_read_enable,
   input  logic              datamem_write_enable,
   input  logic [1:0]        word_size,
   input  logic [1:0]        word_size2,
   input  logic              load_signed,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              access_err,
   output logic [ADDR_W-3:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WAIT, RMW_WRITE} state_t;
   state_t state, state_nxt;
   logic [DATA_W-1:0] merge_q, merged, load_ext, smask;
   logic [4:0] lsh, ssh;
   logic [7:0] lb;
   logic [15:0] lh;
   logic ld_mis, st_mis;

   assign mem_addr = addr[ADDR_W-1:2];
   assign ld_mis = ((word_size2 == 2'b01) & addr[0]) | (word_size2[1] & (|addr[1:0]));
   assign st_mis = ((word_size == 2'b01) & addr[0]) | (word_size[1] & (|addr[1:0]));
   assign lsh = word_size2 == 2'b00 ? {~addr[1:0], 3'b000} : {~addr[1], 4'b0000};
   assign ssh = word_size == 2'b00 ? {~addr[1:0], 3'b000} : {~addr[1], 4'b0000};
   assign lb = 8'(mem_rdata >> lsh);
   assign lh = 16'(mem_rdata >> lsh);
   assign load_ext = word_size2 == 2'b00 ? {{24{load_signed & lb[7]}}, lb}
                   : word_size2 == 2'b01 ? {{16{load_signed & lh[15]}}, lh} : mem_rdata;
   assign smask = (word_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << ssh;
   assign merged = (mem_rdata & ~smask) | ((store_data << ssh) & smask);

   // state register and merge register; the merged word is captured while the RAM read returns
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         merge_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == RMW_WAIT) merge_q <= merged;
      end
   end

   // next state and outputs; everything is held at zero while reset is asserted
   always_comb begin
      state_nxt  = state;
      stall      = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      access_err = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_wdata  = '0;
      if (!rst) begin
         case (state)
            IDLE: begin
               if (datamem_read_enable && datamem_write_enable) access_err = 1'b1;
               else if (datamem_read_enable) begin
                  if (ld_mis) access_err = 1'b1;
                  else begin
                     mem_rd    = 1'b1;
                     stall     = 1'b1;
                     state_nxt = RD_WAIT;
                  end
               end else if (datamem_write_enable) begin
                  if (st_mis) access_err = 1'b1;
                  else if (word_size[1]) begin
                     mem_wr    = 1'b1;
                     mem_wdata = store_data;
                  end else begin
                     mem_rd    = 1'b1;
                     stall     = 1'b1;
                     state_nxt = RMW_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               load_valid = 1'b1;
               load_data  = load_ext;
               state_nxt  = IDLE;
            end
            RMW_WAIT: begin
               stall     = 1'b1;
               state_nxt = RMW_WRITE;
            end
            RMW_WRITE: begin
               mem_wr    = 1'b1;
               mem_wdata = merge_q;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, stores, errors, reset and back-to-back requests
module tb_mem_access_unit;
   logic clk = 1'b0, rst = 1'b1, re = 1'b0, we = 1'b0, sgn = 1'b0;
   logic [1:0] ws = 2'b11, ws2 = 2'b11;
   logic [31:0] addr = '0, sd = '0, mem_rdata = '0;
   logic [31:0] load_data, mem_wdata;
   logic stall, load_valid, access_err, mem_rd, mem_wr;
   logic [29:0] mem_addr;
   logic [31:0] ram [0:63];
   logic pre_we = 1'b0;
   logic [5:0] pre_idx = '0;
   logic [31:0] pre_data = '0;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst(rst),
      .datamem_read_enable(re), .datamem_write_enable(we),
      .word_size(ws), .word_size2(ws2), .load_signed(sgn),
      .addr(addr), .store_data(sd),
      .stall(stall), .load_data(load_data), .load_valid(load_valid), .access_err(access_err),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // synchronous word RAM with a bench-side preload port
   always @(posedge clk) begin
      if (pre_we) ram[pre_idx] <= pre_data;
      else if (mem_wr) ram[mem_addr[5:0]] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr[5:0]];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
   endtask

   task automatic req(input logic r, input logic w, input logic [1:0] s, input logic [1:0] s2,
                      input logic g, input logic [31:0] a, input logic [31:0] d);
      re = r; we = w; ws = s; ws2 = s2; sgn = g; addr = a; sd = d;
   endtask

   task automatic poke(input logic [5:0] i, input logic [31:0] d);
      pre_idx = i; pre_data = d; pre_we = 1'b1;
      tick;
      pre_we = 1'b0;
   endtask

   task automatic test_reset;
      req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
      tick;
      settle;
      checks++;
      if ({stall, load_valid, access_err, mem_rd, mem_wr, load_data, mem_wdata} !== 69'h0) begin
         errors++;
         $display("FAIL reset_during: got %h, expected 0", {stall, load_valid, access_err, mem_rd, mem_wr, load_data, mem_wdata});
      end
      tick;
      rst = 1'b0;
      settle;
      checks++;
      if ({stall, load_valid, access_err, mem_rd, mem_wr, load_data, mem_wdata} !== 69'h0) begin
         errors++;
         $display("FAIL reset_after: got %h, expected 0", {stall, load_valid, access_err, mem_rd, mem_wr, load_data, mem_wdata});
      end
      tick;
   endtask

   task automatic test_load;
      logic [1:0] s2 [0:8];
      logic g [0:8];
      logic [31:0] a [0:8];
      logic [31:0] e [0:8];
      s2 = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
      g  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      a  = '{32'h10, 32'h10, 32'h12, 32'h10, 32'h10, 32'h10, 32'h13, 32'h11, 32'h10};
      e  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_56F0, 32'h8034_56F0, 32'hFFFF_8034,
             32'h0000_8034, 32'hFFFF_FFF0, 32'h0000_0034, 32'h8034_56F0};
      poke(6'd4, 32'h8034_56F0);
      for (int i = 0; i < 9; i++) begin
         req(1, 0, 2'b11, s2[i], g[i], a[i], 32'h0);
         settle;
         checks++;
         if ({stall, mem_rd, load_valid, mem_wr, access_err} !== 5'b11000 || mem_addr !== 30'd4) begin
            errors++;
            $display("FAIL load%0d_issue: stall/rd/valid/wr/err=%b addr=%h, expected 11000 addr=4", i, {stall, mem_rd, load_valid, mem_wr, access_err}, mem_addr);
         end
         tick;
         settle;
         checks++;
         if ({load_valid, stall} !== 2'b10 || load_data !== e[i]) begin
            errors++;
            $display("FAIL load%0d_data: valid/stall=%b data=%h, expected 10 data=%h", i, {load_valid, stall}, load_data, e[i]);
         end
         tick;
      end
      req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
   endtask

   task automatic test_sub_store;
      logic [1:0] s [0:4];
      logic [31:0] a [0:4];
      logic [31:0] d [0:4];
      logic [31:0] e [0:4];
      s = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
      a = '{32'h13, 32'h10, 32'h12, 32'h10, 32'h11};
      d = '{32'h0000_00AB, 32'h0000_BEEF, 32'h1234_BEEF, 32'hFFFF_FF5A, 32'h0000_00C3};
      e = '{32'h1122_33AB, 32'hBEEF_3344, 32'h1122_BEEF, 32'h5A22_3344, 32'h11C3_3344};
      for (int i = 0; i < 5; i++) begin
         poke(6'd4, 32'h1122_3344);
         req(0, 1, s[i], 2'b11, 0, a[i], d[i]);
         settle;
         checks++;
         if ({stall, mem_rd, mem_wr, access_err} !== 4'b1100) begin
            errors++;
            $display("FAIL sst%0d_c1: stall/rd/wr/err=%b, expected 1100", i, {stall, mem_rd, mem_wr, access_err});
         end
         tick;
         settle;
         checks++;
         if ({stall, mem_rd, mem_wr, access_err} !== 4'b1000) begin
            errors++;
            $display("FAIL sst%0d_c2: stall/rd/wr/err=%b, expected 1000", i, {stall, mem_rd, mem_wr, access_err});
         end
         tick;
         settle;
         checks++;
         if ({stall, mem_rd, mem_wr, access_err} !== 4'b0010 || mem_wdata !== e[i] || mem_addr !== 30'd4) begin
            errors++;
            $display("FAIL sst%0d_c3: stall/rd/wr/err=%b wdata=%h addr=%h, expected 0010 wdata=%h addr=4", i, {stall, mem_rd, mem_wr, access_err}, mem_wdata, mem_addr, e[i]);
         end
         tick;
         req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
         checks++;
         if (ram[4] !== e[i]) begin
            errors++;
            $display("FAIL sst%0d_ram: got %h, expected %h", i, ram[4], e[i]);
         end
      end
   endtask

   task automatic test_word_store;
      logic [1:0] s [0:1];
      logic [31:0] a [0:1];
      logic [31:0] d [0:1];
      logic [29:0] w [0:1];
      s = '{2'b11, 2'b10};
      a = '{32'h20, 32'h24};
      d = '{32'hDEAD_BEEF, 32'h0123_4567};
      w = '{30'd8, 30'd9};
      for (int i = 0; i < 2; i++) begin
         req(0, 1, s[i], 2'b11, 0, a[i], d[i]);
         settle;
         checks++;
         if ({stall, mem_rd, mem_wr, access_err} !== 4'b0010 || mem_wdata !== d[i] || mem_addr !== w[i]) begin
            errors++;
            $display("FAIL sw%0d: stall/rd/wr/err=%b wdata=%h addr=%h, expected 0010 wdata=%h addr=%h", i, {stall, mem_rd, mem_wr, access_err}, mem_wdata, mem_addr, d[i], w[i]);
         end
         tick;
         req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
         checks++;
         if (ram[w[i][5:0]] !== d[i]) begin
            errors++;
            $display("FAIL sw%0d_ram: got %h, expected %h", i, ram[w[i][5:0]], d[i]);
         end
      end
   endtask

   task automatic test_errors;
      logic r [0:3];
      logic w [0:3];
      logic [1:0] s [0:3];
      logic [1:0] s2 [0:3];
      logic [31:0] a [0:3];
      r  = '{1'b1, 1'b0, 1'b1, 1'b1};
      w  = '{1'b0, 1'b1, 1'b1, 1'b0};
      s  = '{2'b11, 2'b01, 2'b11, 2'b11};
      s2 = '{2'b11, 2'b11, 2'b11, 2'b01};
      a  = '{32'h21, 32'h23, 32'h10, 32'h11};
      for (int i = 0; i < 4; i++) begin
         req(r[i], w[i], s[i], s2[i], 0, a[i], 32'h0000_BEEF);
         settle;
         checks++;
         if ({access_err, mem_rd, mem_wr, stall, load_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL err%0d: err/rd/wr/stall/valid=%b, expected 10000", i, {access_err, mem_rd, mem_wr, stall, load_valid});
         end
         tick;
      end
      req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
      settle;
      checks++;
      if ({access_err, mem_rd, mem_wr, stall, load_valid} !== 5'b00000) begin
         errors++;
         $display("FAIL err_clear: err/rd/wr/stall/valid=%b, expected 00000", {access_err, mem_rd, mem_wr, stall, load_valid});
      end
      tick;
   endtask

   task automatic test_rst_rmw;
      poke(6'd4, 32'h1122_3344);
      req(0, 1, 2'b00, 2'b11, 0, 32'h13, 32'h0000_00AB);
      settle;
      tick;
      rst = 1'b1;
      req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
      settle;
      checks++;
      if (mem_wr !== 1'b0) begin
         errors++;
         $display("FAIL rst_rmw_wr: mem_wr=%b, expected 0", mem_wr);
      end
      tick;
      rst = 1'b0;
      settle;
      checks++;
      if ({stall, load_valid, access_err, mem_rd, mem_wr, load_data, mem_wdata} !== 69'h0) begin
         errors++;
         $display("FAIL rst_rmw_idle: got %h, expected 0", {stall, load_valid, access_err, mem_rd, mem_wr, load_data, mem_wdata});
      end
      tick;
      settle;
      checks++;
      if (mem_wr !== 1'b0 || ram[4] !== 32'h1122_3344) begin
         errors++;
         $display("FAIL rst_rmw_ram: mem_wr=%b ram=%h, expected 0 11223344", mem_wr, ram[4]);
      end
      tick;
   endtask

   task automatic test_back_to_back;
      poke(6'd4, 32'h8034_56F0);
      req(1, 0, 2'b11, 2'b11, 0, 32'h10, 32'h0);
      settle;
      checks++;
      if ({stall, mem_rd, load_valid} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_c1: stall/rd/valid=%b, expected 110", {stall, mem_rd, load_valid});
      end
      tick;
      settle;
      checks++;
      if ({stall, load_valid} !== 2'b01 || load_data !== 32'h8034_56F0) begin
         errors++;
         $display("FAIL b2b_c2: stall/valid=%b data=%h, expected 01 803456f0", {stall, load_valid}, load_data);
      end
      tick;
      req(0, 1, 2'b11, 2'b11, 0, 32'h20, 32'h0102_0304);
      settle;
      checks++;
      if ({stall, mem_wr, mem_rd} !== 3'b010 || mem_wdata !== 32'h0102_0304 || mem_addr !== 30'd8) begin
         errors++;
         $display("FAIL b2b_c3: stall/wr/rd=%b wdata=%h addr=%h, expected 010 01020304 8", {stall, mem_wr, mem_rd}, mem_wdata, mem_addr);
      end
      tick;
      req(1, 0, 2'b11, 2'b00, 1, 32'h10, 32'h0);
      settle;
      checks++;
      if ({stall, mem_rd, mem_wr} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_c4: stall/rd/wr=%b, expected 110", {stall, mem_rd, mem_wr});
      end
      tick;
      settle;
      checks++;
      if (load_valid !== 1'b1 || load_data !== 32'hFFFF_FF80) begin
         errors++;
         $display("FAIL b2b_c5: valid=%b data=%h, expected 1 ffffff80", load_valid, load_data);
      end
      tick;
      req(0, 0, 2'b11, 2'b11, 0, 32'h0, 32'h0);
   endtask

   initial begin
      test_reset;
      test_load;
      test_sub_store;
      test_word_store;
      test_errors;
      test_rst_rmw;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
